// File: rtl/adc_fifo_drain_scheduler.sv
// Frame-ordered read scheduler for the four per-channel ADC sample FIFOs.
// Drains channels 0..3 in order onto a single valid/ready stream tagged with channel and frame.
module adc_fifo_drain_scheduler #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned RD_LATENCY      = 1,
   parameter int unsigned FRAME_CNT_WIDTH = 16
) (
   input  logic                       system_clock,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [3:0]                 rdempty,
   input  logic [3:0]                 wrfull,
   input  logic [DATA_WIDTH-1:0]      fifo_q0,
   input  logic [DATA_WIDTH-1:0]      fifo_q1,
   input  logic [DATA_WIDTH-1:0]      fifo_q2,
   input  logic [DATA_WIDTH-1:0]      fifo_q3,
   output logic [3:0]                 FIFO_RD_EN,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [1:0]                 out_channel,
   output logic [FRAME_CNT_WIDTH-1:0] out_frame,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic [3:0]                 overflow_sticky,
   input  logic                       clear_overflow
);

   localparam int unsigned WAIT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_PRESENT
   } state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic [1:0]                 ch;
   logic [1:0]                 ch_nxt;
   logic [WAIT_W-1:0]          wait_cnt;
   logic [WAIT_W-1:0]          wait_cnt_nxt;
   logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
   logic [FRAME_CNT_WIDTH-1:0] frame_cnt_nxt;
   logic                       capture_c;
   logic [DATA_WIDTH-1:0]      sel_q_c;
   logic [3:0]                 wrfull_meta;
   logic [3:0]                 wrfull_sync;

   // Read-data mux for the channel currently being drained
   always_comb begin
      sel_q_c = fifo_q0;
      case (ch)
         2'd0:    sel_q_c = fifo_q0;
         2'd1:    sel_q_c = fifo_q1;
         2'd2:    sel_q_c = fifo_q2;
         default: sel_q_c = fifo_q3;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_nxt     = state;
      ch_nxt        = ch;
      wait_cnt_nxt  = wait_cnt;
      frame_cnt_nxt = frame_cnt;
      capture_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable && (rdempty == 4'b0000)) begin
               ch_nxt    = 2'd0;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wait_cnt_nxt = WAIT_W'(RD_LATENCY - 1);
            state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt == WAIT_W'(0)) begin
               capture_c = 1'b1;
               state_nxt = S_PRESENT;
            end else begin
               wait_cnt_nxt = wait_cnt - WAIT_W'(1);
            end
         end
         S_PRESENT: begin
            // out_valid is always high here, so out_ready alone completes the handshake
            if (out_ready) begin
               if (ch == 2'd3) begin
                  frame_cnt_nxt = frame_cnt + FRAME_CNT_WIDTH'(1);
                  state_nxt     = S_IDLE;
               end else begin
                  ch_nxt    = ch + 2'd1;
                  state_nxt = S_ISSUE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control state
   always_ff @(posedge system_clock) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         ch        <= 2'd0;
         wait_cnt  <= WAIT_W'(0);
         frame_cnt <= FRAME_CNT_WIDTH'(0);
      end else begin
         state     <= state_nxt;
         ch        <= ch_nxt;
         wait_cnt  <= wait_cnt_nxt;
         frame_cnt <= frame_cnt_nxt;
      end
   end

   // Registered outputs, decoded from the next state so they align with the state register
   always_ff @(posedge system_clock) begin
      if (!reset_n) begin
         FIFO_RD_EN  <= 4'b0000;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         out_data    <= DATA_WIDTH'(0);
         out_channel <= 2'd0;
         out_frame   <= FRAME_CNT_WIDTH'(0);
         out_last    <= 1'b0;
      end else begin
         FIFO_RD_EN <= (state_nxt == S_ISSUE) ? (4'b0001 << ch_nxt) : 4'b0000;
         out_valid  <= (state_nxt == S_PRESENT);
         busy       <= (state_nxt != S_IDLE);
         if (capture_c) begin
            out_data    <= sel_q_c;
            out_channel <= ch;
            out_frame   <= frame_cnt;
            out_last    <= (ch == 2'd3);
         end
      end
   end

   // wrfull crosses from the write domain; set has priority over clear
   always_ff @(posedge system_clock) begin
      if (!reset_n) begin
         wrfull_meta     <= 4'b0000;
         wrfull_sync     <= 4'b0000;
         overflow_sticky <= 4'b0000;
      end else begin
         wrfull_meta     <= wrfull;
         wrfull_sync     <= wrfull_meta;
         overflow_sticky <= (overflow_sticky & ~{4{clear_overflow}}) | wrfull_sync;
      end
   end

endmodule

// File: tb/tb_adc_fifo_drain_scheduler.sv
// Bench for adc_fifo_drain_scheduler: queue-based FIFO models and a frame-order scoreboard.
// Instance a uses the default latency; instance b uses RD_LATENCY=3 and a 4-bit frame counter.
module tb_adc_fifo_drain_scheduler;

   localparam int unsigned DW    = 32;
   localparam int unsigned LAT_A = 1;
   localparam int unsigned LAT_B = 3;
   localparam int unsigned FCW_B = 4;
   localparam int          MOD_B = 16;

   logic system_clock = 1'b0;
   always #5 system_clock = ~system_clock;

   logic          reset_n, enable, clear_overflow, out_ready;
   logic [3:0]    rdempty, wrfull, FIFO_RD_EN, overflow_sticky;
   logic [DW-1:0] qa [4];
   logic [DW-1:0] out_data;
   logic [1:0]    out_channel;
   logic [15:0]   out_frame;
   logic          out_last, out_valid, busy;

   logic             enable_b, out_ready_b, clear_b;
   logic [3:0]       rdempty_b, wrfull_b, rd_en_b, ovf_b;
   logic [DW-1:0]    qb [4];
   logic [DW-1:0]    out_data_b;
   logic [1:0]       out_channel_b;
   logic [FCW_B-1:0] out_frame_b;
   logic             out_last_b, out_valid_b, busy_b;

   adc_fifo_drain_scheduler dut_a (
      .system_clock(system_clock), .reset_n(reset_n), .enable(enable),
      .rdempty(rdempty), .wrfull(wrfull),
      .fifo_q0(qa[0]), .fifo_q1(qa[1]), .fifo_q2(qa[2]), .fifo_q3(qa[3]),
      .FIFO_RD_EN(FIFO_RD_EN), .out_data(out_data), .out_channel(out_channel),
      .out_frame(out_frame), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .overflow_sticky(overflow_sticky),
      .clear_overflow(clear_overflow)
   );

   adc_fifo_drain_scheduler #(.DATA_WIDTH(DW), .RD_LATENCY(LAT_B), .FRAME_CNT_WIDTH(FCW_B)) dut_b (
      .system_clock(system_clock), .reset_n(reset_n), .enable(enable_b),
      .rdempty(rdempty_b), .wrfull(wrfull_b),
      .fifo_q0(qb[0]), .fifo_q1(qb[1]), .fifo_q2(qb[2]), .fifo_q3(qb[3]),
      .FIFO_RD_EN(rd_en_b), .out_data(out_data_b), .out_channel(out_channel_b),
      .out_frame(out_frame_b), .out_last(out_last_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .busy(busy_b), .overflow_sticky(ovf_b),
      .clear_overflow(clear_b)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Instance a: FIFO contents, words popped but not yet accepted, and stream expectation
   logic [DW-1:0] fq [4][$];
   logic [DW-1:0] exp_q [4][$];
   logic [DW-1:0] pend_a [4];
   logic [3:0]    hist_a [3];
   logic [3:0]    last_rd_a;
   int exp_ch, exp_frame, hs_count;

   // Instance b: bottomless FIFOs whose words encode {channel, pop index}
   logic [DW-1:0] pend_b [4];
   logic [3:0]    hist_b [3];
   logic [3:0]    last_rd_b;
   int pop_b [4];
   int hs_b [4];
   int b_exp_ch, b_exp_frame, b_last_hs, b_hs_total;
   logic b_wrapped;

   task automatic reset_model();
      for (int c = 0; c < 4; c++) begin
         fq[c].delete();
         exp_q[c].delete();
         pop_b[c] = 0;
         hs_b[c]  = 0;
      end
      for (int k = 0; k < 3; k++) begin
         hist_a[k] = 4'b0000;
         hist_b[k] = 4'b0000;
      end
      last_rd_a   = 4'b0000;
      last_rd_b   = 4'b0000;
      rdempty     = 4'hF;
      exp_ch      = 0;
      exp_frame   = 0;
      b_exp_ch    = 0;
      b_exp_frame = 0;
      b_last_hs   = -1;
      b_wrapped   = 1'b0;
   endtask

   task automatic push(input int c, input logic [DW-1:0] w);
      fq[c].push_back(w);
      rdempty[c] = 1'b0;
   endtask

   // One clock: score the cycle ending now, advance, then update the FIFO models
   task automatic step();
      logic [3:0]    tap;
      logic [DW-1:0] w;
      int            gap;
      if (out_valid === 1'b1) begin
         checks++;
         if (exp_q[exp_ch].size() == 0) begin
            failures++;
            $display("FAIL a_word_unexpected got ch=%0d data=%h, no word pending for ch %0d",
                     out_channel, out_data, exp_ch);
         end else begin
            w = exp_q[exp_ch][0];
            if (out_data !== w || out_channel !== 2'(exp_ch) || out_frame !== 16'(exp_frame) ||
                out_last !== (exp_ch == 3)) begin
               failures++;
               $display("FAIL a_word got data=%h ch=%0d frame=%0d last=%b exp data=%h ch=%0d frame=%0d last=%b",
                        out_data, out_channel, out_frame, out_last, w, exp_ch, exp_frame, (exp_ch == 3));
            end
            if (out_ready) begin
               void'(exp_q[exp_ch].pop_front());
               hs_count++;
               if (exp_ch == 3) begin
                  exp_ch    = 0;
                  exp_frame = (exp_frame + 1) % 65536;
               end else begin
                  exp_ch++;
               end
            end
         end
      end
      if (out_valid_b === 1'b1 && out_ready_b) begin
         checks++;
         w = {16'(b_exp_ch), 16'(hs_b[b_exp_ch])};
         if (out_data_b !== w || out_channel_b !== 2'(b_exp_ch) ||
             out_frame_b !== FCW_B'(b_exp_frame) || out_last_b !== (b_exp_ch == 3)) begin
            failures++;
            $display("FAIL b_word got data=%h ch=%0d frame=%0d last=%b exp data=%h ch=%0d frame=%0d",
                     out_data_b, out_channel_b, out_frame_b, out_last_b, w, b_exp_ch, b_exp_frame);
         end
         if (b_last_hs >= 0) begin
            checks++;
            gap = (b_exp_ch == 0) ? int'(LAT_B) + 3 : int'(LAT_B) + 2;
            if (cyc - b_last_hs != gap) begin
               failures++;
               $display("FAIL b_word_period got=%0d exp=%0d", cyc - b_last_hs, gap);
            end
         end
         if (b_exp_ch == 3 && b_exp_frame == MOD_B - 1) b_wrapped = 1'b1;
         b_last_hs = cyc;
         hs_b[b_exp_ch]++;
         b_hs_total++;
         if (b_exp_ch == 3) begin
            b_exp_ch    = 0;
            b_exp_frame = (b_exp_frame + 1) % MOD_B;
         end else begin
            b_exp_ch++;
         end
      end

      @(posedge system_clock);
      #1;
      cyc++;

      hist_a[2] = hist_a[1];
      hist_a[1] = hist_a[0];
      hist_a[0] = last_rd_a;
      tap = hist_a[LAT_A-1];
      for (int c = 0; c < 4; c++) if (tap[c]) qa[c] = pend_a[c];
      if (FIFO_RD_EN !== 4'b0000) begin
         checks++;
         if ($isunknown(FIFO_RD_EN) || $countones(FIFO_RD_EN) != 1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL a_rdreq_shape got rd=%b valid=%b exp one-hot outside PRESENT", FIFO_RD_EN, out_valid);
         end
         for (int c = 0; c < 4; c++) begin
            if (FIFO_RD_EN[c] === 1'b1) begin
               checks++;
               if (fq[c].size() == 0) begin
                  failures++;
                  $display("FAIL a_rdreq_empty got rdreq on ch %0d exp no read of an empty FIFO", c);
               end else begin
                  pend_a[c] = fq[c].pop_front();
                  exp_q[c].push_back(pend_a[c]);
               end
            end
         end
      end
      last_rd_a = FIFO_RD_EN;
      for (int c = 0; c < 4; c++) rdempty[c] = (fq[c].size() == 0);

      hist_b[2] = hist_b[1];
      hist_b[1] = hist_b[0];
      hist_b[0] = last_rd_b;
      tap = hist_b[LAT_B-1];
      for (int c = 0; c < 4; c++) if (tap[c]) qb[c] = pend_b[c];
      if (rd_en_b !== 4'b0000) begin
         checks++;
         if ($isunknown(rd_en_b) || $countones(rd_en_b) != 1 || out_valid_b !== 1'b0) begin
            failures++;
            $display("FAIL b_rdreq_shape got rd=%b valid=%b exp one-hot outside PRESENT", rd_en_b, out_valid_b);
         end
         for (int c = 0; c < 4; c++) begin
            if (rd_en_b[c] === 1'b1) begin
               pend_b[c] = {16'(c), 16'(pop_b[c])};
               pop_b[c]++;
            end
         end
      end
      last_rd_b = rd_en_b;
   endtask

   task automatic run_until_hs(input int target, input int bound, input string name);
      for (int i = 0; i < bound && hs_count < target; i++) step();
      checks++;
      if (hs_count < target) begin
         failures++;
         $display("FAIL %s_timeout got hs=%0d exp hs=%0d", name, hs_count, target);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (FIFO_RD_EN !== 4'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 ||
          out_channel !== 2'd0 || out_frame !== 16'd0 || out_last !== 1'b0 || overflow_sticky !== 4'b0) begin
         failures++;
         $display("FAIL %s got rd=%b v=%b busy=%b data=%h ch=%0d frame=%0d last=%b ovf=%b exp all zero",
                  name, FIFO_RD_EN, out_valid, busy, out_data, out_channel, out_frame, out_last, overflow_sticky);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      reset_model();
      step();
      check_outputs_zero("reset_state");
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single_frame();
      int n0, t_rd, t_v, base;
      logic [3:0] rd_first;
      t_rd = -1; t_v = -1; rd_first = 4'b0;
      base = hs_count;
      push(0, 32'h11110000); push(1, 32'h22220001); push(2, 32'h33330002); push(3, 32'h44440003);
      enable = 1'b1; out_ready = 1'b1;
      n0 = cyc;
      for (int i = 0; i < 40 && hs_count < base + 4; i++) begin
         step();
         if (t_rd < 0 && FIFO_RD_EN !== 4'b0) begin t_rd = cyc; rd_first = FIFO_RD_EN; end
         if (t_v < 0 && out_valid === 1'b1) t_v = cyc;
      end
      checks++;
      if (hs_count != base + 4) begin
         failures++; $display("FAIL single_count got=%0d exp=%0d", hs_count - base, 4);
      end
      checks++;
      if (t_rd != n0 + 1 || rd_first !== 4'b0001) begin
         failures++; $display("FAIL single_rdreq got cycle=%0d rd=%b exp cycle=%0d rd=0001", t_rd - n0, rd_first, 1);
      end
      checks++;
      if (t_v != n0 + 2 + int'(LAT_A)) begin
         failures++; $display("FAIL single_first_valid got=%0d exp=%0d", t_v - n0, 2 + LAT_A);
      end
      step();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL single_idle got busy=%b valid=%b exp 0 0", busy, out_valid);
      end
   endtask

   task automatic test_partial_empty();
      int base;
      base = hs_count;
      for (int c = 0; c < 3; c++) push(c, $urandom);
      for (int i = 0; i < 50; i++) begin
         step();
         checks++;
         if (FIFO_RD_EN !== 4'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL partial_hold got rd=%b valid=%b busy=%b exp 0", FIFO_RD_EN, out_valid, busy);
         end
      end
      push(3, $urandom);
      step();
      checks++;
      if (FIFO_RD_EN !== 4'b0001) begin
         failures++; $display("FAIL partial_start got rd=%b exp=0001", FIFO_RD_EN);
      end
      run_until_hs(base + 4, 60, "partial");
   endtask

   task automatic test_stall();
      int base;
      logic [DW-1:0] w [4];
      base = hs_count;
      for (int c = 0; c < 4; c++) begin w[c] = $urandom; push(c, w[c]); end
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid === 1'b1 && out_channel === 2'd1) break;
         step();
      end
      checks++;
      if (!(out_valid === 1'b1 && out_channel === 2'd1)) begin
         failures++; $display("FAIL stall_reach got valid=%b ch=%0d exp valid on ch 1", out_valid, out_channel);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== w[1] || out_channel !== 2'd1 || FIFO_RD_EN !== 4'b0) begin
            failures++;
            $display("FAIL stall_hold got v=%b data=%h ch=%0d rd=%b exp v=1 data=%h ch=1 rd=0000",
                     out_valid, out_data, out_channel, FIFO_RD_EN, w[1]);
         end
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (FIFO_RD_EN !== 4'b0100) begin
         failures++; $display("FAIL stall_release got rd=%b exp=0100", FIFO_RD_EN);
      end
      run_until_hs(base + 4, 40, "stall");
   endtask

   task automatic test_enable_drop();
      int base;
      base = hs_count;
      for (int k = 0; k < 2; k++) for (int c = 0; c < 4; c++) push(c, $urandom);
      enable = 1'b1;
      step();
      enable = 1'b0;
      run_until_hs(base + 4, 40, "enable_drop");
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (busy !== 1'b0 || FIFO_RD_EN !== 4'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop_idle got busy=%b rd=%b valid=%b exp 0", busy, FIFO_RD_EN, out_valid);
         end
      end
   endtask

   task automatic test_overflow();
      logic [3:0] exp_ovf [3];
      exp_ovf[0] = 4'b0000; exp_ovf[1] = 4'b0000; exp_ovf[2] = 4'b0100;
      wrfull = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         step();
         wrfull = 4'b0000;
         checks++;
         if (overflow_sticky !== exp_ovf[k]) begin
            failures++; $display("FAIL ovf_set_%0d got=%b exp=%b", k + 1, overflow_sticky, exp_ovf[k]);
         end
      end
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      checks++;
      if (overflow_sticky !== 4'b0000) begin
         failures++; $display("FAIL ovf_clear got=%b exp=0000", overflow_sticky);
      end
      wrfull = 4'b0100;
      step();
      wrfull = 4'b0000;
      step();
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      checks++;
      if (overflow_sticky !== 4'b0100) begin
         failures++; $display("FAIL ovf_set_wins got=%b exp=0100", overflow_sticky);
      end
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      step();
      checks++;
      if (overflow_sticky !== 4'b0000) begin
         failures++; $display("FAIL ovf_clear_alone got=%b exp=0000", overflow_sticky);
      end
   endtask

   task automatic test_reset_mid_frame();
      int base;
      for (int c = 0; c < 4; c++) push(c, $urandom);
      enable = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (FIFO_RD_EN === 4'b0100) break;
         step();
      end
      step();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || exp_frame == 0) begin
         failures++; $display("FAIL midreset_setup got busy=%b valid=%b frame=%0d exp busy=1 valid=0 frame>0",
                              busy, out_valid, exp_frame);
      end
      reset_n = 1'b0;
      reset_model();
      step();
      check_outputs_zero("midreset_outputs");
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || FIFO_RD_EN !== 4'b0) begin
            failures++; $display("FAIL midreset_stale got valid=%b rd=%b exp 0", out_valid, FIFO_RD_EN);
         end
      end
      base = hs_count;
      for (int c = 0; c < 4; c++) push(c, $urandom);
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
      checks++;
      if (out_valid !== 1'b1 || out_channel !== 2'd0 || out_frame !== 16'd0) begin
         failures++; $display("FAIL midreset_restart got v=%b ch=%0d frame=%0d exp v=1 ch=0 frame=0",
                              out_valid, out_channel, out_frame);
      end
      run_until_hs(base + 4, 40, "midreset");
   endtask

   task automatic test_wrap_latency3();
      int n0, t_v;
      t_v = -1;
      b_last_hs = -1;
      enable_b = 1'b1; out_ready_b = 1'b1;
      n0 = cyc;
      for (int i = 0; i < 1000 && b_hs_total < 17 * 4; i++) begin
         step();
         if (t_v < 0 && out_valid_b === 1'b1) t_v = cyc;
      end
      enable_b = 1'b0;
      checks++;
      if (b_hs_total < 17 * 4) begin
         failures++; $display("FAIL wrap_timeout got=%0d exp=%0d", b_hs_total, 17 * 4);
      end
      checks++;
      if (t_v != n0 + 2 + int'(LAT_B)) begin
         failures++; $display("FAIL wrap_first_valid got=%0d exp=%0d", t_v - n0, 2 + LAT_B);
      end
      checks++;
      if (b_wrapped !== 1'b1 || b_exp_frame != 1) begin
         failures++; $display("FAIL wrap_seen got wrapped=%b next_frame=%0d exp 1 1", b_wrapped, b_exp_frame);
      end
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (busy_b !== 1'b0 || ovf_b !== 4'b0) begin
         failures++; $display("FAIL wrap_idle got busy=%b ovf=%b exp 0", busy_b, ovf_b);
      end
   endtask

   task automatic test_random();
      int base;
      base = hs_count;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < 4; c++)
            if ($urandom_range(0, 3) == 0 && fq[c].size() < 8) push(c, $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         enable    = ($urandom_range(0, 15) != 0);
         step();
      end
      enable = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 200 && busy !== 1'b0; i++) step();
      checks++;
      if (busy !== 1'b0 || (hs_count - base) % 4 != 0 || hs_count - base < 40) begin
         failures++; $display("FAIL random_drain got busy=%b words=%0d exp busy=0 whole frames >=40",
                              busy, hs_count - base);
      end
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; clear_overflow = 1'b0; out_ready = 1'b0;
      wrfull = 4'b0; rdempty = 4'hF;
      enable_b = 1'b0; out_ready_b = 1'b0; clear_b = 1'b0; wrfull_b = 4'b0; rdempty_b = 4'b0;
      for (int c = 0; c < 4; c++) begin qa[c] = '0; qb[c] = '0; pend_a[c] = '0; pend_b[c] = '0; end
      hs_count = 0; b_hs_total = 0;
      reset_model();
      step(); step();
      test_reset();
      test_single_frame();
      test_partial_empty();
      test_stall();
      test_enable_drop();
      test_overflow();
      test_reset_mid_frame();
      test_wrap_latency3();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
